if_id_fetch_queue: RTL and testbench

IF_ID_FETCH_QUEUE -- requirements
Module: if_id_fetch_queue

---
 rtl/if_id_fetch_queue_pkg.sv | 6 +
 rtl/if_id_fetch_queue_ptr.sv | 15 +
 rtl/if_id_fetch_queue.sv | 44 ++++
 tb/tb_if_id_fetch_queue.sv | 118 +++++++++++
 4 files changed

// File: rtl/if_id_fetch_queue_pkg.sv
// if_id_fetch_queue_pkg: shared pipeline constants for the IF/ID fetch queue
package if_id_fetch_queue_pkg;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [31:0] NOP = 32'b0;
endpackage

// File: rtl/if_id_fetch_queue_ptr.sv
// fq_ptr_counter: wrapping queue pointer with increment and synchronous clear
module fq_ptr_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + W'(1);
endmodule

// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: IF/ID instruction FIFO with flush, zero-latency head read
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign in_ready  = count < FULL;
    assign out_valid = count != '0;
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;
    fq_ptr_counter #(.W(AW)) u_wr (.clk(clk), .rst(rst), .clr(flush), .inc(push), .ptr(wr_ptr));
    fq_ptr_counter #(.W(AW)) u_rd (.clk(clk), .rst(rst), .clr(flush), .inc(pop),  .ptr(rd_ptr));
    // storage is never cleared; emptiness is tracked by count alone
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_pc, in_instr};
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (flush) count <= '0;
        else if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
    always_comb begin
        out_pc    = out_valid ? mem[rd_ptr][2*WIDTH-1:WIDTH] : WIDTH'(NOP);
        out_instr = out_valid ? mem[rd_ptr][WIDTH-1:0]       : WIDTH'(NOP);
    end
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb_if_id_fetch_queue: directed and random scoreboard bench for the fetch queue
module tb_if_id_fetch_queue;
    localparam int DEPTH = 4;
    logic        clk = 0;
    logic        rst = 1;
    logic        flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_pc = 0, in_instr = 0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;
    int passed = 0, total = 0;
    logic [63:0] sb [$];

    always #5 clk = ~clk;

    if_id_fetch_queue #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .in_instr(in_instr), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_instr(out_instr), .out_ready(out_ready), .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_state();
        int n = sb.size();
        chk("count", 64'(count), 64'(n));
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        chk("in_ready", 64'(in_ready), 64'(n < DEPTH));
        chk("out_pc", 64'(out_pc), n != 0 ? 64'(sb[0][63:32]) : 64'd0);
        chk("out_instr", 64'(out_instr), n != 0 ? 64'(sb[0][31:0]) : 64'd0);
    endtask

    // called at a negedge: drive inputs, check outputs, clock once, update model
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        logic do_push, do_pop;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
        check_state();
        do_push = v && sb.size() < DEPTH && !fl;
        do_pop  = ordy && sb.size() != 0 && !fl;
        @(posedge clk);
        if (fl) sb.delete();
        else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back({pc, ins});
        end
        @(negedge clk);
        in_valid = 0; out_ready = 0; flush = 0;
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hA5C3_0000;
    endfunction

    initial begin
        #2 rst = 0;
        #1 check_state();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        // push 0x0, 0x4, 0x8 without consuming
        for (int i = 0; i < 3; i++) cycle(1, 32'(4 * i), ins_of(32'(4 * i)), 0, 0);
        chk("r31_count", 64'(count), 64'd3);
        chk("r31_in_ready", 64'(in_ready), 64'd1);
        chk("r31_out_pc", 64'(out_pc), 64'h0);
        // fill, then hold a push against a full queue
        cycle(1, 32'hC, ins_of(32'hC), 0, 0);
        cycle(1, 32'h10, ins_of(32'h10), 0, 0);
        chk("r32_in_ready", 64'(in_ready), 64'd0);
        chk("r32_count_full", 64'(count), 64'd4);
        cycle(1, 32'h10, ins_of(32'h10), 1, 0);
        chk("r32_count_pop", 64'(count), 64'd3);
        chk("r32_out_pc", 64'(out_pc), 64'h4);
        // drain to two entries, then streaming push+pop across pointer wrap
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cycle(1, 32'h100 + 32'(4 * i), ins_of(32'h100 + 32'(4 * i)), 1, 0);
        chk("r33_count", 64'(count), 64'd2);
        chk("r33_out_pc", 64'(out_pc), 64'h120);
        // flush beats a simultaneous push and pop
        cycle(1, 32'h200, ins_of(32'h200), 0, 0);
        chk("r34_pre_count", 64'(count), 64'd3);
        cycle(1, 32'h99, ins_of(32'h99), 1, 1);
        chk("r34_count", 64'(count), 64'd0);
        chk("r34_out_valid", 64'(out_valid), 64'd0);
        chk("r34_out_instr", 64'(out_instr), 64'd0);
        // one-cycle write-to-read latency, no bypass
        in_valid = 1; in_pc = 32'h20; in_instr = 32'hE3A01005;
        #1 chk("r35_push_cycle_valid", 64'(out_valid), 64'd0);
        cycle(1, 32'h20, 32'hE3A01005, 0, 0);
        chk("r35_out_valid", 64'(out_valid), 64'd1);
        chk("r35_out_pc", 64'(out_pc), 64'h20);
        chk("r35_out_instr", 64'(out_instr), 64'hE3A01005);
        // asynchronous reset mid-operation
        cycle(1, 32'h24, ins_of(32'h24), 0, 0);
        chk("r36_pre_count", 64'(count), 64'd2);
        #1 rst = 0;
        #1 chk("r36_count", 64'(count), 64'd0);
        chk("r36_out_valid", 64'(out_valid), 64'd0);
        sb.delete();
        #1 rst = 1;
        @(negedge clk);
        cycle(1, 32'h300, ins_of(32'h300), 0, 0);
        chk("r36_first_push", 64'(count), 64'd1);
        // random traffic against the model
        for (int i = 0; i < 200; i++) begin
            logic [31:0] pc = 32'h1000 + 32'(4 * i);
            cycle(1'($urandom_range(0, 1)), pc, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0);
        end
        check_state();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
